digdar_bus_reader: RTL and testbench

Bus-initiator block that drains a captured scope buffer over the system bus. On a start command it issues sequential 32-bit reads (one outstanding at a time) starting at a base address. It pushes each returned word into a small output FIFO presented as a valid/ready stream with a last-word flag. It sits on the sys-clock side of the bus clock bridge and is the reading end of the scope's sample-buffer read path, replacing software polling of the 0x1xxxx–0x4xxxx buffer windows.

---
 rtl/digdar_pkg.sv | 20 ++
 rtl/digdar_sync_fifo.sv | 55 +++++
 rtl/digdar_bus_reader.sv | 181 ++++++++++++++++++
 tb/tb_digdar_bus_reader.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digdar_pkg.sv
// Shared types and constants for the digdar scope read path.
package digdar_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } rd_state_e;

    localparam logic [31:0] AddrInc        = 32'd4;
    localparam int unsigned DefaultTimeout = 255;

    // Scope sample-buffer windows on the system bus.
    localparam logic [31:0] BufWin1 = 32'h0001_0000;
    localparam logic [31:0] BufWin2 = 32'h0002_0000;
    localparam logic [31:0] BufWin3 = 32'h0003_0000;
    localparam logic [31:0] BufWin4 = 32'h0004_0000;

endpackage

// File: rtl/digdar_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy output.
module digdar_sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_wr,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_rd,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_occ
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_wr;
    logic w_rd;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr    = i_wr && !w_full && !i_flush;
    assign w_rd    = i_rd && !w_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    // Gate the head so the outputs read zero whenever nothing is presented.
    assign o_rdata = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign o_valid = !w_empty;
    assign o_occ   = r_wptr - r_rptr;

endmodule

// File: rtl/digdar_bus_reader.sv
// Bus initiator draining a scope buffer into a valid/ready stream.
// Define DIGDAR_BUS_READER_TIMEOUT_EN to enable the ack timeout.
module digdar_bus_reader
    import digdar_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = DefaultTimeout,
    parameter int unsigned NW         = 15
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          start_i,
    input  logic [31:0]   base_addr_i,
    input  logic [NW-1:0] n_words_i,
    input  logic          abort_i,
    output logic [31:0]   sys_addr_o,
    output logic          sys_ren_o,
    input  logic [31:0]   sys_rdata_i,
    input  logic          sys_ack_i,
    input  logic          sys_err_i,
    output logic [31:0]   m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic          m_last_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int unsigned OccW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_bad_param
        $error("digdar_bus_reader: FIFO_DEPTH must be a power of two >= 2, TIMEOUT >= 1");
    end

    rd_state_e     r_state;
    rd_state_e     w_state_d;
    logic [31:0]   r_addr;
    logic [31:0]   w_addr_d;
    logic [NW-1:0] r_rem;
    logic [NW-1:0] w_rem_d;
    logic          r_done;
    logic          w_done_d;
    logic          r_err;
    logic          w_err_d;

    logic            w_abort;
    logic            w_timeout;
    logic            w_flush;
    logic            w_ren;
    logic            w_fifo_wr;
    logic            w_fifo_rd;
    logic            w_fifo_valid;
    logic [32:0]     w_fifo_wdata;
    logic [32:0]     w_fifo_rdata;
    logic [OccW-1:0] w_occ;

    assign w_abort      = abort_i && (r_state != StIdle);
    assign w_fifo_rd    = w_fifo_valid && m_ready_i;
    assign w_fifo_wdata = {(r_rem == NW'(1)), sys_rdata_i};

`ifdef DIGDAR_BUS_READER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] r_cnt;

    // Fires on the WAIT cycle whose increment would reach TIMEOUT.
    assign w_timeout = (r_state == StWait) && !sys_ack_i && (r_cnt == CntW'(TIMEOUT - 1));

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_cnt <= '0;
        end else if (w_ren) begin
            r_cnt <= '0;
        end else if (r_state == StWait && !sys_ack_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;
        w_rem_d   = r_rem;
        w_done_d  = 1'b0;
        w_err_d   = 1'b0;
        w_flush   = 1'b0;
        w_ren     = 1'b0;
        w_fifo_wr = 1'b0;
        if (w_abort) begin
            w_flush   = 1'b1;
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start_i && !r_done) begin
                        w_addr_d = base_addr_i;
                        w_rem_d  = n_words_i;
                        if (n_words_i == '0) w_done_d  = 1'b1;
                        else                 w_state_d = StReq;
                    end
                end
                StReq: begin
                    if (32'(w_occ) < FIFO_DEPTH) begin
                        w_ren     = 1'b1;
                        w_state_d = StWait;
                    end
                end
                StWait: begin
                    if (sys_ack_i) begin
                        if (sys_err_i) begin
                            w_err_d   = 1'b1;
                            w_flush   = 1'b1;
                            w_state_d = StIdle;
                        end else begin
                            w_fifo_wr = 1'b1;
                            w_addr_d  = r_addr + AddrInc;
                            w_rem_d   = r_rem - NW'(1);
                            w_state_d = (r_rem == NW'(1)) ? StDrain : StReq;
                        end
                    end else if (w_timeout) begin
                        w_err_d   = 1'b1;
                        w_flush   = 1'b1;
                        w_state_d = StIdle;
                    end
                end
                StDrain: begin
                    if (w_fifo_rd && w_fifo_rdata[32]) begin
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_addr  <= w_addr_d;
            r_rem   <= w_rem_d;
            r_done  <= w_done_d;
            r_err   <= w_err_d;
        end
    end

    digdar_sync_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (sys_clk_i),
        .i_rst   (sys_rst_i),
        .i_flush (w_flush),
        .i_wr    (w_fifo_wr),
        .i_wdata (w_fifo_wdata),
        .i_rd    (w_fifo_rd),
        .o_rdata (w_fifo_rdata),
        .o_valid (w_fifo_valid),
        .o_occ   (w_occ)
    );

    assign sys_addr_o = r_addr;
    assign sys_ren_o  = w_ren;
    assign m_data_o   = w_fifo_rdata[31:0];
    assign m_last_o   = w_fifo_rdata[32];
    assign m_valid_o  = w_fifo_valid;
    assign busy_o     = (r_state != StIdle);
    assign done_o     = r_done;
    assign err_o      = r_err;

endmodule

// File: tb/tb_digdar_bus_reader.sv
// Directed bench for digdar_bus_reader with a scripted bus slave and stream sink.
module tb_digdar_bus_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [14:0] nwords = '0;
    logic        abort = 1'b0;
    logic [31:0] sys_addr;
    logic        sys_ren;
    logic [31:0] sys_rdata = '0;
    logic        sys_ack = 1'b0;
    logic        sys_err = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        err;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Responder controls (main) and state (responder only).
    bit          resp_en = 1'b0;
    int          resp_lat = 3;
    int          err_idx = 0;
    int          stray_req = 0;
    int          stray_done = 0;
    int          pend = 0;
    int          pend_idx = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] ren_q[$];
    int unsigned last_ren_cyc = 0;

    // Sink state (monitor only).
    logic [32:0] out_q[$];
    int          done_cnt = 0;
    int          err_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    digdar_bus_reader #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (10),
        .NW         (15)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst),
        .start_i     (start),
        .base_addr_i (base),
        .n_words_i   (nwords),
        .abort_i     (abort),
        .sys_addr_o  (sys_addr),
        .sys_ren_o   (sys_ren),
        .sys_rdata_i (sys_rdata),
        .sys_ack_i   (sys_ack),
        .sys_err_i   (sys_err),
        .m_data_o    (m_data),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_last_o    (m_last),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    // Bus slave: acts 1 time unit after each edge.
    always begin
        @(posedge clk);
        #1;
        sys_ack   = 1'b0;
        sys_err   = 1'b0;
        sys_rdata = '0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                sys_ack   = 1'b1;
                sys_rdata = mem_word(pend_addr);
                sys_err   = (pend_idx == err_idx);
            end
        end
        if (stray_req != stray_done) begin
            stray_done++;
            sys_ack   = 1'b1;
            sys_rdata = 32'hBAD0_BAD0;
        end
        if (sys_ren) begin
            ren_q.push_back(sys_addr);
            last_ren_cyc = cyc;
            if (resp_en) begin
                pend      = resp_lat;
                pend_addr = sys_addr;
                pend_idx  = ren_q.size();
            end
        end
    end

    // Stream sink and pulse counters: sample 4 units after each edge.
    always begin
        @(posedge clk);
        #4;
        if (m_valid && m_ready) out_q.push_back({m_last, m_data});
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic start_run(input logic [31:0] b, input logic [14:0] n);
        base   = b;
        nwords = n;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_not_busy(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (!busy) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({sys_addr, m_data} !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_addr_data: got %h required 0", {sys_addr, m_data});
        end
        n_cmp++;
        if ({sys_ren, m_valid, m_last, busy, done, err} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 000000",
                     {sys_ren, m_valid, m_last, busy, done, err});
        end
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({sys_ren, busy, m_valid} !== 3'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b required 000", {sys_ren, busy, m_valid});
        end
    endtask

    task automatic test_basic();
        int rb = ren_q.size();
        int ob = out_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit ok;
        logic [32:0] exp;
        resp_en  = 1'b1;
        resp_lat = 3;
        m_ready  = 1'b1;
        start_run(32'h0001_0000, 15'd4);
        n_cmp++;
        if ({busy, sys_ren, sys_addr} !== {2'b11, 32'h0001_0000}) begin
            n_bad++;
            $display("FAIL basic_first_ren: got busy=%b ren=%b addr=%h required 1 1 00010000",
                     busy, sys_ren, sys_addr);
        end
        wait_not_busy(100, ok);
        n_cmp++;
        if (ok !== 1'b1 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_done_with_busy_fall: got ok=%b done=%b required 1 1", ok, done);
        end
        repeat (3) tick();
        n_cmp++;
        if (ren_q.size() - rb !== 4) begin
            n_bad++;
            $display("FAIL basic_ren_count: got %0d required 4", ren_q.size() - rb);
        end
        for (int i = 0; i < 4 && rb + i < ren_q.size(); i++) begin
            n_cmp++;
            if (ren_q[rb+i] !== 32'h0001_0000 + 32'(4 * i)) begin
                n_bad++;
                $display("FAIL basic_addr%0d: got %h required %h", i, ren_q[rb+i],
                         32'h0001_0000 + 32'(4 * i));
            end
        end
        n_cmp++;
        if (out_q.size() - ob !== 4) begin
            n_bad++;
            $display("FAIL basic_out_count: got %0d required 4", out_q.size() - ob);
        end
        for (int i = 0; i < 4 && ob + i < out_q.size(); i++) begin
            exp = {(i == 3), mem_word(32'h0001_0000 + 32'(4 * i))};
            n_cmp++;
            if (out_q[ob+i] !== exp) begin
                n_bad++;
                $display("FAIL basic_word%0d: got %h required %h", i, out_q[ob+i], exp);
            end
        end
        n_cmp++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            n_bad++;
            $display("FAIL basic_pulses: got done=%0d err=%0d required 1 0",
                     done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_backpressure();
        int rb = ren_q.size();
        int ob = out_q.size();
        int d0 = done_cnt;
        bit ok;
        logic [32:0] exp;
        resp_en  = 1'b1;
        resp_lat = 2;
        m_ready  = 1'b0;
        start_run(32'h0003_0000, 15'd6);
        repeat (40) tick();
        n_cmp++;
        if (ren_q.size() - rb !== 4 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_stall: got reads=%0d busy=%b required 4 1", ren_q.size() - rb, busy);
        end
        n_cmp++;
        if ({m_valid, m_last, m_data} !== {2'b10, mem_word(32'h0003_0000)}) begin
            n_bad++;
            $display("FAIL bp_head_hold: got v=%b l=%b d=%h required 1 0 %h",
                     m_valid, m_last, m_data, mem_word(32'h0003_0000));
        end
        m_ready = 1'b1;
        tick();
        tick();
        m_ready = 1'b0;
        repeat (30) tick();
        n_cmp++;
        if (ren_q.size() - rb !== 6 || out_q.size() - ob !== 2) begin
            n_bad++;
            $display("FAIL bp_second_stall: got reads=%0d out=%0d required 6 2",
                     ren_q.size() - rb, out_q.size() - ob);
        end
        n_cmp++;
        if ({m_valid, m_data} !== {1'b1, mem_word(32'h0003_0008)}) begin
            n_bad++;
            $display("FAIL bp_head_third: got v=%b d=%h required 1 %h",
                     m_valid, m_data, mem_word(32'h0003_0008));
        end
        m_ready = 1'b1;
        wait_not_busy(100, ok);
        repeat (3) tick();
        n_cmp++;
        if (ok !== 1'b1 || out_q.size() - ob !== 6 || done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL bp_complete: got ok=%b out=%0d done=%0d required 1 6 1",
                     ok, out_q.size() - ob, done_cnt - d0);
        end
        for (int i = 0; i < 6 && ob + i < out_q.size(); i++) begin
            exp = {(i == 5), mem_word(32'h0003_0000 + 32'(4 * i))};
            n_cmp++;
            if (out_q[ob+i] !== exp) begin
                n_bad++;
                $display("FAIL bp_word%0d: got %h required %h", i, out_q[ob+i], exp);
            end
        end
    endtask

    task automatic test_bus_error();
        int rb = ren_q.size();
        int ob = out_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit seen = 1'b0;
        resp_en  = 1'b1;
        resp_lat = 2;
        m_ready  = 1'b0;
        err_idx  = rb + 2;
        start_run(32'h0004_0000, 15'd4);
        for (int i = 0; i < 50; i++) begin
            if (err) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (seen !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse_state: got seen=%b busy=%b valid=%b required 1 0 0",
                     seen, busy, m_valid);
        end
        repeat (5) tick();
        n_cmp++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1 || ren_q.size() - rb !== 2) begin
            n_bad++;
            $display("FAIL err_counts: got done=%0d err=%0d reads=%0d required 0 1 2",
                     done_cnt - d0, err_cnt - e0, ren_q.size() - rb);
        end
        n_cmp++;
        if (out_q.size() - ob !== 0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_aftermath: got out=%0d err=%b required 0 0", out_q.size() - ob, err);
        end
        err_idx = 0;
    endtask

    task automatic test_timeout();
        int ob = out_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        resp_en = 1'b0;
        m_ready = 1'b1;
        start_run(32'h0001_0000, 15'd1);
`ifdef DIGDAR_BUS_READER_TIMEOUT_EN
        begin
            bit seen = 1'b0;
            int unsigned ren_at = last_ren_cyc;
            int unsigned err_at = 0;
            for (int i = 0; i < 40; i++) begin
                if (err) begin
                    seen   = 1'b1;
                    err_at = cyc;
                    break;
                end
                tick();
            end
            n_cmp++;
            if (seen !== 1'b1 || err_at - ren_at !== 11) begin
                n_bad++;
                $display("FAIL timeout_latency: got seen=%b delta=%0d required 1 11",
                         seen, err_at - ren_at);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_busy: got %b required 0", busy);
            end
            stray_req++;
            repeat (3) tick();
            n_cmp++;
            if (m_valid !== 1'b0 || out_q.size() - ob !== 0 || done_cnt - d0 !== 0
                || err_cnt - e0 !== 1) begin
                n_bad++;
                $display("FAIL timeout_late_ack: got v=%b out=%0d done=%0d err=%0d required 0 0 0 1",
                         m_valid, out_q.size() - ob, done_cnt - d0, err_cnt - e0);
            end
        end
`else
        repeat (300) tick();
        n_cmp++;
        if (busy !== 1'b1 || err_cnt - e0 !== 0) begin
            n_bad++;
            $display("FAIL wait_holds: got busy=%b err=%0d required 1 0", busy, err_cnt - e0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (busy !== 1'b0 || err_cnt - e0 !== 0 || done_cnt - d0 !== 0
            || out_q.size() - ob !== 0) begin
            n_bad++;
            $display("FAIL wait_abort: got busy=%b err=%0d done=%0d out=%0d required 0 0 0 0",
                     busy, err_cnt - e0, done_cnt - d0, out_q.size() - ob);
        end
`endif
    endtask

    task automatic test_abort();
        int rb = ren_q.size();
        int ob = out_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit ok;
        resp_en = 1'b0;
        m_ready = 1'b1;
        start_run(32'h0001_0000, 15'd3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({busy, done, err} !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_state: got busy=%b done=%b err=%b required 0 0 0", busy, done, err);
        end
        resp_en  = 1'b1;
        resp_lat = 3;
        stray_req++;
        start_run(32'h0002_0000, 15'd1);
        n_cmp++;
        if ({sys_ren, sys_addr} !== {1'b1, 32'h0002_0000}) begin
            n_bad++;
            $display("FAIL abort_new_ren: got ren=%b addr=%h required 1 00020000", sys_ren, sys_addr);
        end
        wait_not_busy(50, ok);
        repeat (3) tick();
        n_cmp++;
        if (ok !== 1'b1 || ren_q.size() - rb !== 2 || out_q.size() - ob !== 1) begin
            n_bad++;
            $display("FAIL abort_rerun_counts: got ok=%b reads=%0d out=%0d required 1 2 1",
                     ok, ren_q.size() - rb, out_q.size() - ob);
        end
        if (out_q.size() > ob) begin
            n_cmp++;
            if (out_q[ob] !== {1'b1, mem_word(32'h0002_0000)}) begin
                n_bad++;
                $display("FAIL abort_rerun_word: got %h required %h", out_q[ob],
                         {1'b1, mem_word(32'h0002_0000)});
            end
        end
        n_cmp++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            n_bad++;
            $display("FAIL abort_pulses: got done=%0d err=%0d required 1 0",
                     done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_zero_and_wrap();
        int rb = ren_q.size();
        int ob = out_q.size();
        int d0 = done_cnt;
        bit ok;
        resp_en  = 1'b1;
        resp_lat = 1;
        m_ready  = 1'b1;
        start_run(32'h1234_0000, 15'd0);
        n_cmp++;
        if ({done, busy, sys_ren} !== 3'b100) begin
            n_bad++;
            $display("FAIL zero_done: got done=%b busy=%b ren=%b required 1 0 0", done, busy, sys_ren);
        end
        start_run(32'h0001_0000, 15'd5);
        n_cmp++;
        if ({busy, sys_ren} !== 2'b00) begin
            n_bad++;
            $display("FAIL start_on_done_ignored: got busy=%b ren=%b required 0 0", busy, sys_ren);
        end
        repeat (3) tick();
        n_cmp++;
        if (ren_q.size() - rb !== 0 || done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL zero_counts: got reads=%0d done=%0d required 0 1",
                     ren_q.size() - rb, done_cnt - d0);
        end
        start_run(32'hFFFF_FFFC, 15'd2);
        wait_not_busy(50, ok);
        repeat (3) tick();
        n_cmp++;
        if (ok !== 1'b1 || ren_q.size() - rb !== 2 || out_q.size() - ob !== 2) begin
            n_bad++;
            $display("FAIL wrap_counts: got ok=%b reads=%0d out=%0d required 1 2 2",
                     ok, ren_q.size() - rb, out_q.size() - ob);
        end
        if (ren_q.size() - rb == 2) begin
            n_cmp++;
            if ({ren_q[rb], ren_q[rb+1]} !== {32'hFFFF_FFFC, 32'h0000_0000}) begin
                n_bad++;
                $display("FAIL wrap_addr: got %h %h required fffffffc 00000000",
                         ren_q[rb], ren_q[rb+1]);
            end
        end
        if (out_q.size() - ob == 2) begin
            n_cmp++;
            if ({out_q[ob], out_q[ob+1]} !== {1'b0, mem_word(32'hFFFF_FFFC),
                                              1'b1, mem_word(32'h0000_0000)}) begin
                n_bad++;
                $display("FAIL wrap_words: got %h %h required %h %h", out_q[ob], out_q[ob+1],
                         {1'b0, mem_word(32'hFFFF_FFFC)}, {1'b1, mem_word(32'h0000_0000)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bus_error();
        test_timeout();
        test_abort();
        test_zero_and_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
